// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: bit-serial WIDTH-bit adder.
// Operands are accepted over a valid/ready handshake and added LSB first
// through one full-adder cell with a registered carry. The WIDTH-bit sum
// and carry-out are then offered on a valid/ready output handshake.
module serial_adder_fsm #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    bit_cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;
  logic             accept;
  logic             release_out;

  // Full-adder cell on the current LSB pair and the registered carry.
  always_comb begin
    fa_s = a_sh[0] ^ b_sh[0] ^ carry;
    fa_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  end

  // Sum shift register with the new bit inserted at the MSB end.
  always_comb begin
    sum_next            = sum_sh >> 1;
    sum_next[WIDTH-1]   = fa_s;
  end

  // Handshake and bit-count qualifiers.
  always_comb begin
    last_bit    = (bit_cnt == CW'(WIDTH - 1));
    accept      = (state == IDLE) && in_valid;
    release_out = (state == DONE) && out_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = DONE;
      DONE:    if (release_out) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == SHIFT);
    out_valid = (state == DONE);
  end

  // Operand shifters, carry, bit counter and result capture.
  // The result is copied into sum_q/cout_q on the final SHIFT edge so it
  // survives the next operand load (which clears sum_sh) until the next DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            carry   <= cin;
            bit_cnt <= '0;
            sum_sh  <= '0;
          end
        end
        SHIFT: begin
          sum_sh <= sum_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_c;
          if (last_bit) begin
            sum_q  <= sum_next;
            cout_q <= fa_c;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result outputs.
  always_comb begin
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Bench for serial_adder_fsm: directed cases plus randomized adds on a
// WIDTH=8 instance, and the full truth table on a WIDTH=1 instance.
module tb_serial_adder_fsm;

  logic       clk;
  int         total;
  int         bad;

  // WIDTH=8 instance signals
  logic       rst8, in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
  logic [7:0] a8, b8, sum8;

  // WIDTH=1 instance signals
  logic       rst1, in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [0:0] a1, b1, sum1;

  serial_adder_fsm #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8)
  );

  serial_adder_fsm #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 transaction; called and returns at a negedge.
  // hold: cycles out_ready stays low after out_valid rises.
  // pulse: drive a stray operand pair during SHIFT.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input int hold, input bit pulse);
    logic [8:0] exp;
    int         lat;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
    check("in_ready_idle", in_ready8, 1'b1);
    in_valid8  = 1'b1;
    a8 = a; b8 = b; cin8 = c;
    out_ready8 = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    check("busy_after_accept", busy8, 1'b1);
    check("in_ready_busy", in_ready8, 1'b0);
    lat = 0;
    while (!out_valid8 && lat < 64) begin
      if (pulse && lat == 2) begin
        in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
      end else begin
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    in_valid8 = 1'b0;
    check("latency", 64'(lat), 64'd8);
    check("sum", sum8, exp[7:0]);
    check("cout", cout8, exp[8]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid8, 1'b1);
      check("bp_in_ready", in_ready8, 1'b0);
      check("bp_sum_cout", {cout8, sum8}, exp);
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    check("post_hs_in_ready", in_ready8, 1'b1);
    check("post_hs_out_valid", out_valid8, 1'b0);
    check("post_hs_retain", {cout8, sum8}, exp);
  endtask

  initial begin
    total = 0; bad = 0;
    rst8 = 1'b1; in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b0;
    rst1 = 1'b1; in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready8, 1'b1);
    check("rst_out_valid", out_valid8, 1'b0);
    check("rst_busy", busy8, 1'b0);
    check("rst_sum_cout", {cout8, sum8}, 9'd0);
    check("rst1_state", {in_ready1, out_valid1, busy1, cout1, sum1}, 5'b10000);
    rst8 = 1'b0; rst1 = 1'b0;

    // Directed cases
    add8(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    add8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    add8(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    add8(8'h12, 8'h34, 1'b1, 5, 1'b0);
    add8(8'h0F, 8'hF0, 1'b0, 0, 1'b1);

    // Reset after three SHIFT cycles
    in_valid8 = 1'b1; a8 = 8'hC3; b8 = 8'h7E; cin8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (2) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("midrst_in_ready", in_ready8, 1'b1);
    check("midrst_busy", busy8, 1'b0);
    check("midrst_out_valid", out_valid8, 1'b0);
    check("midrst_sum_cout", {cout8, sum8}, 9'd0);
    begin
      int rises;
      rises = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_valid8) rises++;
      end
      check("midrst_no_result", 64'(rises), 64'd0);
    end
    add8(8'h01, 8'h01, 1'b0, 0, 1'b0);

    // Randomized adds with random backpressure and stray input pulses
    for (int n = 0; n < 24; n++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      add8(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] exp1;
      v = 3'(i);
      exp1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      in_valid1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      @(posedge clk);
      @(negedge clk);
      in_valid1 = 1'b0;
      check("w1_busy", {busy1, out_valid1}, 2'b10);
      @(negedge clk);
      check("w1_out_valid", out_valid1, 1'b1);
      check("w1_result", {cout1, sum1}, exp1);
      @(negedge clk);
      check("w1_in_ready", in_ready1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
